// File: rtl/fetch_unit_pkg.sv
// rtl/fetch_unit_pkg.sv - shared cpu definitions used by fetch and decode
package fetch_unit_pkg;
  localparam int ADDR_W = 32;
  localparam int INST_W = 32;
  localparam int ENTRY_W = ADDR_W + INST_W;
  localparam logic [ADDR_W-1:0] PC_INC = 32'd4;
  localparam logic [INST_W-1:0] NOP_INST = 32'h0;

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [INST_W-1:0] inst;
  } fetchEntry_t;

  function automatic logic [ADDR_W-1:0] alignPc(input logic [ADDR_W-1:0] pc);
    return pc & ~32'h3;
  endfunction
endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - prefetch queue of {pc, inst} entries with flush
module fetch_fifo
  import fetch_unit_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [ENTRY_W-1:0]       pushData,
  input  logic                     pop,
  input  logic                     flush,
  output logic [ENTRY_W-1:0]       headData,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [ENTRY_W-1:0] mem [DEPTH];
  logic [PW-1:0]      rdPtr;
  logic [PW-1:0]      wrPtr;
  logic               doPop;

  assign empty    = (count == '0);
  assign full     = (count == CW'(DEPTH));
  assign doPop    = pop && !empty;
  assign headData = mem[rdPtr];

  // Pointers are exactly PW bits wide, so DEPTH being a power of two gives the wrap for free.
  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      rdPtr <= '0;
      wrPtr <= '0;
      count <= '0;
    end else begin
      if (push) wrPtr <= wrPtr + PW'(1);
      if (doPop) rdPtr <= rdPtr + PW'(1);
      if (push && !doPop) count <= count + CW'(1);
      else if (doPop && !push) count <= count - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush) mem[wrPtr] <= pushData;
  end
endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch: PC sequencing, one-deep memory pipeline, prefetch queue
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [ADDR_W-1:0]  pc;
  logic [ADDR_W-1:0]  reqPc;
  logic               inFlight;
  logic               issue;
  logic               push;
  logic               pop;
  logic               fifoFull;
  logic               fifoEmpty;
  logic [CW-1:0]      fifoCount;
  logic [ENTRY_W-1:0] headRaw;
  fetchEntry_t        pushEntry;
  fetchEntry_t        head;

  // Occupancy counts the outstanding response so the queue can never overflow; a pop frees space only next cycle.
  assign issue = rst_n && !redirect && ((fifoCount + CW'(inFlight)) < CW'(DEPTH));
  assign push  = rst_n && !redirect && inFlight && !fifoFull;
  assign pop   = inst_valid && inst_ready;

  assign pushEntry.pc   = reqPc;
  assign pushEntry.inst = imem_rdata;
  assign head           = fetchEntry_t'(headRaw);

  assign imem_req   = issue;
  assign imem_addr  = rst_n ? pc : RESET_PC;
  assign inst_valid = rst_n && !fifoEmpty;
  assign inst       = inst_valid ? head.inst : NOP_INST;
  assign inst_pc    = inst_valid ? head.pc : '0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc       <= RESET_PC;
      reqPc    <= RESET_PC;
      inFlight <= 1'b0;
    end else if (redirect) begin
      pc       <= alignPc(redirect_pc);
      inFlight <= 1'b0;
    end else begin
      inFlight <= issue;
      if (issue) begin
        reqPc <= pc;
        pc    <= pc + PC_INC;
      end
    end
  end

  fetch_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (push),
    .pushData (pushEntry),
    .pop      (pop),
    .flush    (redirect),
    .headData (headRaw),
    .full     (fifoFull),
    .empty    (fifoEmpty),
    .count    (fifoCount)
  );
endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed scenarios plus randomized scoreboard for fetch_unit
module tb_fetch_unit;
  localparam int          DEPTH    = 4;
  localparam logic [31:0] WRAP_PC  = 32'hFFFF_FFF8;
  localparam logic [31:0] DATA_OFS = 32'd100;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n = 1'b0, redirect = 1'b0, inst_ready = 1'b1;
  logic [31:0] redirect_pc = 32'h0;
  logic        imem_req, inst_valid;
  logic [31:0] imem_addr, imem_rdata, inst, inst_pc;

  logic        wRedirect = 1'b0, wReady = 1'b1;
  logic [31:0] wRedirectPc = 32'h0;
  logic        wReq, wValid;
  logic [31:0] wAddr, wRdata, wInst, wPc;

  int passCnt = 0;
  int totalCnt = 0;
  int reqCnt;

  logic [31:0] mq[$];
  logic        pendValid = 1'b0;
  logic [31:0] pendPc = 32'h0;
  logic [31:0] mpc = 32'h0;
  logic        expValid, expReq;
  logic [31:0] wrapExp [4] = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0, 32'h4};

  fetch_unit #(.RESET_PC(32'h0), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .redirect(redirect), .redirect_pc(redirect_pc),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst), .inst_pc(inst_pc)
  );

  fetch_unit #(.RESET_PC(WRAP_PC), .DEPTH(DEPTH)) dutWrap (
    .clk(clk), .rst_n(rst_n), .imem_req(wReq), .imem_addr(wAddr),
    .imem_rdata(wRdata), .redirect(wRedirect), .redirect_pc(wRedirectPc),
    .inst_valid(wValid), .inst_ready(wReady), .inst(wInst), .inst_pc(wPc)
  );

  // Memory answers addr+100 one cycle after a request, garbage otherwise.
  always @(posedge clk) imem_rdata <= imem_req ? imem_addr + DATA_OFS : $urandom();
  always @(posedge clk) wRdata <= wReq ? wAddr + DATA_OFS : $urandom();

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    totalCnt++;
    if (act === exp) passCnt++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic checkBit(input string name, input logic act, input logic exp);
    totalCnt++;
    if (act === exp) passCnt++;
    else $display("FAIL %s: got %b, expected %b", name, act, exp);
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic resetFor(input int n, input logic ready);
    rst_n = 1'b0;
    redirect = 1'b0;
    inst_ready = ready;
    repeat (n) nextCycle();
    rst_n = 1'b1;
  endtask

  // Reference model: a queue of PCs waiting downstream plus at most one outstanding memory read.
  initial forever begin
    @(negedge clk);
    expValid = rst_n && (mq.size() > 0);
    expReq   = rst_n && !redirect && ((mq.size() + (pendValid ? 1 : 0)) < DEPTH);
    checkBit("model inst_valid", inst_valid, expValid);
    checkBit("model imem_req", imem_req, expReq);
    check("model imem_addr", imem_addr, rst_n ? mpc : 32'h0);
    if (expValid) begin
      check("model inst_pc", inst_pc, mq[0]);
      check("model inst", inst, mq[0] + DATA_OFS);
    end else if (!rst_n) begin
      check("reset inst", inst, 32'h0);
      check("reset inst_pc", inst_pc, 32'h0);
    end
    if (!rst_n) begin
      mq.delete();
      pendValid = 1'b0;
      mpc = 32'h0;
    end else if (redirect) begin
      mq.delete();
      pendValid = 1'b0;
      mpc = redirect_pc & 32'hFFFF_FFFC;
    end else begin
      if (expValid && inst_ready) void'(mq.pop_front());
      if (pendValid) mq.push_back(pendPc);
      pendValid = expReq;
      pendPc = mpc;
      if (expReq) mpc = mpc + 32'd4;
    end
  end

  initial begin
    // Boot with ready high: requests 0,4,8 then one instruction per cycle; wrap instance crosses 2^32.
    resetFor(2, 1'b1);
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (c < 3) begin
        checkBit("boot imem_req", imem_req, 1'b1);
        check("boot imem_addr", imem_addr, 32'(c * 4));
      end
      if (c < 2) checkBit("boot inst_valid low", inst_valid, 1'b0);
      else begin
        checkBit("boot inst_valid", inst_valid, 1'b1);
        check("boot inst_pc", inst_pc, 32'((c - 2) * 4));
        checkBit("wrap inst_valid", wValid, 1'b1);
        check("wrap inst_pc", wPc, wrapExp[c - 2]);
      end
      if (c == 2) begin
        check("boot inst", inst, 32'd100);
        check("wrap inst", wInst, 32'h0000_005C);
      end
      nextCycle();
    end

    // Downstream stalled for 10 cycles.
    resetFor(1, 1'b0);
    reqCnt = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (imem_req) begin
        if (reqCnt < 4) check("stall imem_addr", imem_addr, 32'(reqCnt * 4));
        reqCnt++;
      end
      if (c >= 2) begin
        checkBit("stall inst_valid", inst_valid, 1'b1);
        check("stall inst_pc", inst_pc, 32'h0);
      end
      nextCycle();
    end
    check("stall request count", 32'(reqCnt), 32'd4);
    inst_ready = 1'b1;
    for (int c = 10; c < 14; c++) begin
      @(negedge clk);
      check("drain inst_pc", inst_pc, 32'((c - 10) * 4));
      if (c == 11) begin
        checkBit("resume imem_req", imem_req, 1'b1);
        check("resume imem_addr", imem_addr, 32'd16);
      end
      nextCycle();
    end

    // Redirect with 3 queued and 1 in flight.
    resetFor(1, 1'b0);
    repeat (4) nextCycle();
    redirect = 1'b1;
    redirect_pc = 32'h0000_0203;
    @(negedge clk);
    checkBit("redirect cycle inst_valid", inst_valid, 1'b1);
    checkBit("redirect cycle imem_req", imem_req, 1'b0);
    nextCycle();
    redirect = 1'b0;
    inst_ready = 1'b1;
    @(negedge clk);
    checkBit("post redirect inst_valid", inst_valid, 1'b0);
    checkBit("post redirect imem_req", imem_req, 1'b1);
    check("post redirect imem_addr", imem_addr, 32'h200);
    nextCycle();
    nextCycle();
    @(negedge clk);
    checkBit("redirect target inst_valid", inst_valid, 1'b1);
    check("redirect target inst_pc", inst_pc, 32'h200);
    check("redirect target inst", inst, 32'h264);
    nextCycle();

    // Back-to-back redirects: the later target wins.
    redirect = 1'b1;
    redirect_pc = 32'd40;
    @(negedge clk);
    checkBit("double redirect 1 imem_req", imem_req, 1'b0);
    nextCycle();
    redirect_pc = 32'd80;
    @(negedge clk);
    checkBit("double redirect 2 imem_req", imem_req, 1'b0);
    checkBit("double redirect 2 inst_valid", inst_valid, 1'b0);
    nextCycle();
    redirect = 1'b0;
    @(negedge clk);
    checkBit("double redirect fetch req", imem_req, 1'b1);
    check("double redirect fetch addr", imem_addr, 32'd80);
    nextCycle();
    nextCycle();
    @(negedge clk);
    check("double redirect inst_pc", inst_pc, 32'd80);
    nextCycle();

    // One-cycle reset with 2 queued and 1 in flight.
    resetFor(1, 1'b0);
    repeat (3) nextCycle();
    rst_n = 1'b0;
    inst_ready = 1'b1;
    @(negedge clk);
    checkBit("mid reset inst_valid", inst_valid, 1'b0);
    checkBit("mid reset imem_req", imem_req, 1'b0);
    nextCycle();
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (c < 2) checkBit("after reset no stale word", inst_valid, 1'b0);
      else begin
        checkBit("after reset inst_valid", inst_valid, 1'b1);
        check("after reset inst_pc", inst_pc, 32'h0);
        check("after reset inst", inst, 32'd100);
      end
      nextCycle();
    end

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      inst_ready = ($urandom_range(0, 9) < 7);
      redirect = ($urandom_range(0, 19) == 0);
      redirect_pc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom();
      rst_n = ($urandom_range(0, 99) != 0);
      nextCycle();
    end
    rst_n = 1'b1;
    redirect = 1'b0;
    repeat (2) nextCycle();

    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end
endmodule
